// File: rtl/spi_eeprom_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_eeprom_sequencer : single-byte read/write sequencer for 25xx SPI EEPROMs
// Revision: 1.0
// ----------------------------------------------------------------------------
module spi_eeprom_sequencer #(
    parameter logic [15:0] POLL_MAX = 16'd2000,
    parameter logic [1:0]  CLK_DIV  = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        spi_start,
    output logic        spi_continued,
    output logic [7:0]  spi_txData,
    output logic [1:0]  spi_clkDiv,
    input  logic        spi_ready,
    input  logic [7:0]  spi_rxData
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WREN      = 4'd1,
        S_WR_CMD    = 4'd2,
        S_WR_AH     = 4'd3,
        S_WR_AL     = 4'd4,
        S_WR_DATA   = 4'd5,
        S_RDSR_CMD  = 4'd6,
        S_RDSR_DATA = 4'd7,
        S_RD_CMD    = 4'd8,
        S_RD_AH     = 4'd9,
        S_RD_AL     = 4'd10,
        S_RD_DATA   = 4'd11,
        S_DONE      = 4'd12,
        S_ERR       = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        P_ISSUE     = 2'd0,
        P_WAIT_ACK  = 2'd1,
        P_WAIT_DONE = 2'd2
    } phase_t;

    state_t      r_state, w_state_n;
    phase_t      r_phase, w_phase_n;
    logic        r_we, w_we_n;
    logic [15:0] r_addr, w_addr_n;
    logic [7:0]  r_wdata, w_wdata_n;
    logic [15:0] r_poll, w_poll_n;
    logic [15:0] w_poll_inc;
    logic [7:0]  r_rdata, w_rdata_n;
    logic        r_start, w_start_n;
    logic        r_cont, w_cont_n;
    logic [7:0]  r_tx, w_tx_n;

    logic        w_is_byte;
    logic [7:0]  w_byte_tx;
    logic        w_byte_cont;
    state_t      w_byte_next;

    assign spi_clkDiv    = CLK_DIV;
    assign spi_start     = r_start;
    assign spi_continued = r_cont;
    assign spi_txData    = r_tx;
    assign rdata         = r_rdata;
    assign w_poll_inc    = r_poll + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_phase <= P_ISSUE;
            r_we    <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 8'h00;
            r_poll  <= 16'h0000;
            r_rdata <= 8'h00;
            r_start <= 1'b0;
            r_cont  <= 1'b0;
            r_tx    <= 8'hFF;
        end else begin
            r_state <= w_state_n;
            r_phase <= w_phase_n;
            r_we    <= w_we_n;
            r_addr  <= w_addr_n;
            r_wdata <= w_wdata_n;
            r_poll  <= w_poll_n;
            r_rdata <= w_rdata_n;
            r_start <= w_start_n;
            r_cont  <= w_cont_n;
            r_tx    <= w_tx_n;
        end
    end

    // Byte to send, CE-hold flag and successor for every byte-transfer state
    always_comb begin
        w_is_byte   = 1'b1;
        w_byte_tx   = 8'hFF;
        w_byte_cont = 1'b0;
        w_byte_next = S_IDLE;
        case (r_state)
            S_WREN:      begin w_byte_tx = 8'h06;         w_byte_cont = 1'b0; w_byte_next = S_WR_CMD;    end
            S_WR_CMD:    begin w_byte_tx = 8'h02;         w_byte_cont = 1'b1; w_byte_next = S_WR_AH;     end
            S_WR_AH:     begin w_byte_tx = r_addr[15:8];  w_byte_cont = 1'b1; w_byte_next = S_WR_AL;     end
            S_WR_AL:     begin w_byte_tx = r_addr[7:0];   w_byte_cont = 1'b1; w_byte_next = S_WR_DATA;   end
            S_WR_DATA:   begin w_byte_tx = r_wdata;       w_byte_cont = 1'b0; w_byte_next = S_RDSR_CMD;  end
            S_RDSR_CMD:  begin w_byte_tx = 8'h05;         w_byte_cont = 1'b1; w_byte_next = S_RDSR_DATA; end
            S_RDSR_DATA: begin w_byte_tx = 8'hFF;         w_byte_cont = 1'b0; w_byte_next = S_DONE;      end
            S_RD_CMD:    begin w_byte_tx = 8'h03;         w_byte_cont = 1'b1; w_byte_next = S_RD_AH;     end
            S_RD_AH:     begin w_byte_tx = r_addr[15:8];  w_byte_cont = 1'b1; w_byte_next = S_RD_AL;     end
            S_RD_AL:     begin w_byte_tx = r_addr[7:0];   w_byte_cont = 1'b1; w_byte_next = S_RD_DATA;   end
            S_RD_DATA:   begin w_byte_tx = 8'hFF;         w_byte_cont = 1'b0; w_byte_next = S_DONE;      end
            default:     w_is_byte = 1'b0;
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        w_phase_n = r_phase;
        w_we_n    = r_we;
        w_addr_n  = r_addr;
        w_wdata_n = r_wdata;
        w_poll_n  = r_poll;
        w_rdata_n = r_rdata;
        w_start_n = 1'b0;
        w_cont_n  = r_cont;
        w_tx_n    = r_tx;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;

        if (w_is_byte) begin
            case (r_phase)
                P_ISSUE: begin
                    if (spi_ready) begin
                        w_start_n = 1'b1;
                        w_tx_n    = w_byte_tx;
                        w_cont_n  = w_byte_cont;
                        w_phase_n = P_WAIT_ACK;
                    end
                end
                P_WAIT_ACK: begin
                    if (!spi_ready) w_phase_n = P_WAIT_DONE;
                end
                P_WAIT_DONE: begin
                    if (spi_ready) begin
                        w_phase_n = P_ISSUE;
                        w_state_n = w_byte_next;
                        if (r_state == S_RD_DATA) w_rdata_n = spi_rxData;
                        // Write-in-progress still set: poll again or give up
                        if (r_state == S_RDSR_DATA && spi_rxData[0]) begin
                            w_poll_n  = w_poll_inc;
                            w_state_n = (w_poll_inc == POLL_MAX) ? S_ERR : S_RDSR_CMD;
                        end
                    end
                end
                default: w_phase_n = P_ISSUE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    busy      = 1'b0;
                    w_phase_n = P_ISSUE;
                    if (req) begin
                        w_we_n    = req_we;
                        w_addr_n  = req_addr;
                        w_wdata_n = req_wdata;
                        w_poll_n  = 16'h0000;
                        w_state_n = req_we ? S_WREN : S_RD_CMD;
                    end
                end
                S_DONE: begin
                    done      = 1'b1;
                    w_state_n = S_IDLE;
                end
                S_ERR: begin
                    done      = 1'b1;
                    err       = 1'b1;
                    w_state_n = S_IDLE;
                end
                default: begin
                    busy      = 1'b0;
                    w_state_n = S_IDLE;
                    w_phase_n = P_ISSUE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_eeprom_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_eeprom_sequencer : directed self-checking bench with a byte-engine model
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_eeprom_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        busy, done, err;
    logic [7:0]  rdata;
    logic        spi_start, spi_continued;
    logic [7:0]  spi_txData;
    logic [1:0]  spi_clkDiv;
    logic        spi_ready;
    logic [7:0]  spi_rxData;

    logic        eng_ready, eng_busy;
    int          eng_cnt;
    logic        hold_low = 1'b0;
    logic [7:0]  default_rx = 8'h00;
    logic [7:0]  rx_q[$];
    logic [8:0]  log_q[$];
    logic [8:0]  exp_q[$];
    int          starts = 0;
    int          run = 0;
    int          max_run = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign spi_ready = eng_ready & ~hold_low;

    spi_eeprom_sequencer #(.POLL_MAX(16'd4), .CLK_DIV(2'b01)) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .spi_start(spi_start), .spi_continued(spi_continued),
        .spi_txData(spi_txData), .spi_clkDiv(spi_clkDiv),
        .spi_ready(spi_ready), .spi_rxData(spi_rxData)
    );

    // Byte-engine model: 0xFF bytes return queued (or default) data, others 0x00
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_ready  <= 1'b1;
            eng_busy   <= 1'b0;
            eng_cnt    <= 0;
            spi_rxData <= 8'h00;
        end else if (eng_busy) begin
            if (eng_cnt == 0) begin
                eng_busy  <= 1'b0;
                eng_ready <= 1'b1;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end else if (spi_start && spi_ready) begin
            log_q.push_back({spi_continued, spi_txData});
            eng_ready <= 1'b0;
            eng_busy  <= 1'b1;
            eng_cnt   <= 3;
            if (spi_txData == 8'hFF) begin
                if (rx_q.size() > 0) spi_rxData <= rx_q.pop_front();
                else                 spi_rxData <= default_rx;
            end else begin
                spi_rxData <= 8'h00;
            end
        end
    end

    always @(posedge clk) begin
        if (spi_start) begin
            starts++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag);
        chk({tag, " byte_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < log_q.size())
                chk($sformatf("%s byte%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    endtask

    task automatic issue(input logic we, input logic [15:0] a, input logic [7:0] d);
        req = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(negedge clk);
        req = 1'b0;
    endtask

    // Waits (bounded) for done, checks err/rdata on that cycle and the idle cycle after
    task automatic wait_done(input string tag, input logic exp_err, input logic [7:0] exp_rdata);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done_seen"}, 32'(done), 32'd1);
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        chk({tag, " rdata"}, 32'(rdata), 32'(exp_rdata));
        @(negedge clk);
        chk({tag, " done_pulse_end"}, 32'(done), 32'd0);
        chk({tag, " busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int s0;
        int n;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst rdata", 32'(rdata), 32'h00);
        chk("rst start", 32'(spi_start), 32'd0);
        chk("rst cont", 32'(spi_continued), 32'd0);
        chk("rst txData", 32'(spi_txData), 32'hFF);
        chk("rst clkDiv", 32'(spi_clkDiv), 32'h1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: read 0x12A5
        log_q.delete(); rx_q = {8'h3C};
        issue(1'b0, 16'h12A5, 8'h00);
        chk("t1 busy", 32'(busy), 32'd1);
        wait_done("t1", 1'b0, 8'h3C);
        exp_q = {9'h103, 9'h112, 9'h1A5, 9'h0FF};
        chk_log("t1");

        // 2: write 0x5A to 0x0040, two busy polls then ready
        log_q.delete(); rx_q = {8'h03, 8'h03, 8'h02};
        issue(1'b1, 16'h0040, 8'h5A);
        wait_done("t2", 1'b0, 8'h3C);
        exp_q = {9'h006, 9'h102, 9'h100, 9'h140, 9'h05A};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(9'h105);
            exp_q.push_back(9'h0FF);
        end
        chk_log("t2");

        // 3: status stuck busy -> timeout after POLL_MAX=4 polls
        log_q.delete(); rx_q.delete(); default_rx = 8'h01;
        issue(1'b1, 16'h0010, 8'h77);
        wait_done("t3", 1'b1, 8'h3C);
        exp_q = {9'h006, 9'h102, 9'h100, 9'h110, 9'h077};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(9'h105);
            exp_q.push_back(9'h0FF);
        end
        chk_log("t3");
        default_rx = 8'h00;

        // 4: req held high; second read accepted only after busy falls
        log_q.delete(); rx_q = {8'h11, 8'h22};
        s0 = starts;
        req = 1'b1; req_we = 1'b0; req_addr = 16'h0102; req_wdata = 8'h00;
        @(negedge clk);
        wait_done("t4a", 1'b0, 8'h11);
        @(negedge clk);
        chk("t4 second accepted", 32'(busy), 32'd1);
        req = 1'b0;
        wait_done("t4b", 1'b0, 8'h22);
        chk("t4 start count", 32'(starts - s0), 32'd8);
        exp_q = {9'h103, 9'h101, 9'h102, 9'h0FF, 9'h103, 9'h101, 9'h102, 9'h0FF};
        chk_log("t4");

        // 5: reset asserted during WR_AH aborts immediately
        log_q.delete(); rx_q.delete();
        issue(1'b1, 16'h0300, 8'h11);
        n = 0;
        while (log_q.size() < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5 reached WR_AH", 32'(log_q.size()), 32'd3);
        chk("t5 WR_AH tx", 32'(spi_txData), 32'h03);
        rst_n = 1'b0;
        #1;
        chk("t5 rst busy", 32'(busy), 32'd0);
        chk("t5 rst start", 32'(spi_start), 32'd0);
        chk("t5 rst cont", 32'(spi_continued), 32'd0);
        chk("t5 rst txData", 32'(spi_txData), 32'hFF);
        chk("t5 rst rdata", 32'(rdata), 32'h00);
        chk("t5 rst done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        log_q.delete(); rx_q = {8'hA7};
        issue(1'b0, 16'h0001, 8'h00);
        wait_done("t5", 1'b0, 8'hA7);
        exp_q = {9'h103, 9'h100, 9'h101, 9'h0FF};
        chk_log("t5");

        // 6: byte engine not ready for 50 cycles
        log_q.delete(); rx_q = {8'h5B};
        hold_low = 1'b1;
        s0 = starts;
        issue(1'b0, 16'h0002, 8'h00);
        repeat (50) @(negedge clk);
        chk("t6 no start while not ready", 32'(starts - s0), 32'd0);
        chk("t6 busy while waiting", 32'(busy), 32'd1);
        hold_low = 1'b0;
        wait_done("t6", 1'b0, 8'h5B);
        exp_q = {9'h103, 9'h100, 9'h102, 9'h0FF};
        chk_log("t6");
        chk("t6 start width", 32'(max_run), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
